// File: rtl/pim_result_accumulator.sv
// pim_result_accumulator
// Adds up the K_TILES partial-product tiles that one PIM multiply unit emits for
// one output tile. The finished tile is handed to the result writer over a
// valid/ready handshake. Up to two finished tiles can be held: one in the output
// register and one in the accumulator while in FULL. While in FULL the block
// holds in_ready low so no more partial tiles come in.
module pim_result_accumulator #(
   parameter int ELEM_WIDTH      = 32,
   parameter int PIM_MATRIX_SIZE = 8,
   parameter int K_TILES         = 4
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   in_valid,
   input  logic [ELEM_WIDTH*PIM_MATRIX_SIZE*PIM_MATRIX_SIZE-1:0]  in_tile,
   output logic                                                   in_ready,
   output logic                                                   out_valid,
   output logic [ELEM_WIDTH*PIM_MATRIX_SIZE*PIM_MATRIX_SIZE-1:0]  out_tile,
   input  logic                                                   out_ready,
   output logic [$clog2(K_TILES+1)-1:0]                           k_count,
   output logic [15:0]                                            tile_count,
   output logic                                                   drop_err
);

   localparam int N_ELEM = PIM_MATRIX_SIZE * PIM_MATRIX_SIZE;
   localparam int TILE_W = ELEM_WIDTH * N_ELEM;
   localparam int KW     = $clog2(K_TILES + 1);
   localparam logic [KW-1:0] K_LAST = KW'(K_TILES - 1);

   typedef enum logic {
      ACCUM,
      FULL
   } state_t;

   state_t              r_state;
   logic [TILE_W-1:0]   r_acc;
   logic [KW-1:0]       r_k;
   logic [TILE_W-1:0]   r_out_tile;
   logic                r_out_valid;
   logic [15:0]         r_tile_count;
   logic                r_drop_err;

   logic [TILE_W-1:0]   w_sum;
   logic                w_out_free;
   logic                w_accept;
   logic                w_handshake;

   assign in_ready    = (r_state == ACCUM);
   assign w_out_free  = !r_out_valid || out_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_handshake = r_out_valid && out_ready;

   assign out_valid  = r_out_valid;
   assign out_tile   = r_out_tile;
   assign k_count    = r_k;
   assign tile_count = r_tile_count;
   assign drop_err   = r_drop_err;

   // Element-wise sum of the incoming tile with the running partial sum.
   // The first partial of a tile replaces the sum, so acc never needs clearing.
   always_comb begin
      w_sum = '0;
      for (int unsigned e = 0; e < N_ELEM; e++) begin
         if (r_k == '0)
            w_sum[e*ELEM_WIDTH +: ELEM_WIDTH] = in_tile[e*ELEM_WIDTH +: ELEM_WIDTH];
         else
            w_sum[e*ELEM_WIDTH +: ELEM_WIDTH] = r_acc[e*ELEM_WIDTH +: ELEM_WIDTH]
                                              + in_tile[e*ELEM_WIDTH +: ELEM_WIDTH];
      end
   end

   // Accumulation / hand-off FSM together with the output register and status counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ACCUM;
         r_acc        <= '0;
         r_k          <= '0;
         r_out_tile   <= '0;
         r_out_valid  <= 1'b0;
         r_tile_count <= '0;
         r_drop_err   <= 1'b0;
      end else begin
         // A handshake frees the output register. A load later in this block
         // may set it valid again in the same cycle.
         if (w_handshake) begin
            r_out_valid  <= 1'b0;
            r_tile_count <= r_tile_count + 16'd1;
         end

         if (in_valid && !in_ready)
            r_drop_err <= 1'b1;

         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  if (r_k == K_LAST) begin
                     r_k <= '0;
                     if (w_out_free) begin
                        r_out_tile  <= w_sum;
                        r_out_valid <= 1'b1;
                     end else begin
                        r_acc   <= w_sum;
                        r_state <= FULL;
                     end
                  end else begin
                     r_acc <= w_sum;
                     r_k   <= r_k + KW'(1);
                  end
               end
            end
            FULL: begin
               if (w_out_free) begin
                  r_out_tile  <= r_acc;
                  r_out_valid <= 1'b1;
                  r_state     <= ACCUM;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_pim_result_accumulator.sv
// Testbench for pim_result_accumulator. The reference model keeps a queue of
// finished tiles that have not been handed off yet, plus a running sum and a
// count of partials. in_ready and out_valid follow from how full the queue is.
module tb_pim_result_accumulator;

   localparam int W  = 32;
   localparam int N  = 8;
   localparam int K  = 4;
   localparam int NE = N * N;
   localparam int TW = W * NE;
   localparam int KW = $clog2(K + 1);

   typedef logic [TW-1:0] tile_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   tile_t         in_tile;
   logic          in_ready;
   logic          out_valid;
   tile_t         out_tile;
   logic          out_ready;
   logic [KW-1:0] k_count;
   logic [15:0]   tile_count;
   logic          drop_err;

   pim_result_accumulator #(
      .ELEM_WIDTH      (W),
      .PIM_MATRIX_SIZE (N),
      .K_TILES         (K)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_tile    (in_tile),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_tile   (out_tile),
      .out_ready  (out_ready),
      .k_count    (k_count),
      .tile_count (tile_count),
      .drop_err   (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   tile_t m_q[$];
   tile_t m_psum;
   int    m_k;
   int    m_tiles;
   bit    m_drop;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic tile_t tile_fill(input logic [W-1:0] v);
      tile_t t;
      for (int e = 0; e < NE; e++) t[e*W +: W] = v;
      return t;
   endfunction

   function automatic tile_t tile_add(input tile_t a, input tile_t b);
      tile_t t;
      for (int e = 0; e < NE; e++) t[e*W +: W] = a[e*W +: W] + b[e*W +: W];
      return t;
   endfunction

   function automatic tile_t tile_rand();
      tile_t t;
      for (int e = 0; e < NE; e++) t[e*W +: W] = $urandom();
      return t;
   endfunction

   // Compares a whole tile. It reports the first element that differs, or element 0 if none differs.
   task automatic check_tile(input string tag, input tile_t obs, input tile_t exp);
      int idx;
      idx = 0;
      for (int e = NE - 1; e >= 0; e--)
         if (obs[e*W +: W] !== exp[e*W +: W]) idx = e;
      check($sformatf("%s_e%0d", tag, idx), 64'(obs[idx*W +: W]), 64'(exp[idx*W +: W]));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_psum  = '0;
      m_k     = 0;
      m_tiles = 0;
      m_drop  = 1'b0;
   endtask

   // One clock: check the outputs at negedge, advance the model with the current inputs, then cross the edge.
   task automatic step();
      bit room;
      bit hs;
      @(negedge clk);
      check("in_ready",   64'(in_ready),   64'(m_q.size() < 2));
      check("out_valid",  64'(out_valid),  64'(m_q.size() > 0));
      if (m_q.size() > 0) check_tile("out_tile", out_tile, m_q[0]);
      check("k_count",    64'(k_count),    64'(m_k));
      check("tile_count", 64'(tile_count), 64'(m_tiles));
      check("drop_err",   64'(drop_err),   64'(m_drop));
      if (rst) begin
         model_reset();
      end else begin
         room = (m_q.size() < 2);
         hs   = (m_q.size() > 0) && out_ready;
         if (in_valid && !room) m_drop = 1'b1;
         if (hs) begin
            void'(m_q.pop_front());
            m_tiles = (m_tiles + 1) % 65536;
         end
         if (in_valid && room) begin
            m_psum = tile_add(m_psum, in_tile);
            m_k++;
            if (m_k == K) begin
               m_q.push_back(m_psum);
               m_psum = '0;
               m_k    = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input tile_t t, input bit ordy);
      in_valid  = 1'b1;
      in_tile   = t;
      out_ready = ordy;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic idle(input int n, input bit ordy);
      in_valid  = 1'b0;
      out_ready = ordy;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_tile   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_k_count",   64'(k_count),   64'd0);
      check("rst_tile_cnt",  64'(tile_count), 64'd0);
      check("rst_drop_err",  64'(drop_err),  64'd0);
      check_tile("rst_out_tile", out_tile, '0);
      rst = 1'b0;

      // Basic sum 1+2+3+4 = 10
      for (int v = 1; v <= 4; v++) send(tile_fill(W'(v)), 1'b1);
      check("t1_valid", 64'(out_valid), 64'd1);
      check_tile("t1_tile", out_tile, tile_fill(32'd10));
      check("t1_kc", 64'(k_count), 64'd0);
      idle(1, 1'b1);
      check("t1_valid_clr", 64'(out_valid), 64'd0);
      check("t1_tc", 64'(tile_count), 64'd1);

      // Modulo wrap
      send(tile_fill(32'hFFFF_FFFF), 1'b1);
      send(tile_fill(32'd2), 1'b1);
      send(tile_fill(32'd0), 1'b1);
      send(tile_fill(32'd0), 1'b1);
      check_tile("t2_wrap", out_tile, tile_fill(32'd1));
      idle(2, 1'b1);

      // Back-pressure: 10 then 20 held; drop while FULL; then drain
      for (int v = 1; v <= 4; v++) send(tile_fill(W'(v)), 1'b0);
      for (int v = 1; v <= 4; v++) send(tile_fill(W'(2 * v)), 1'b0);
      check("t3_in_ready_full", 64'(in_ready), 64'd0);
      send(tile_fill(32'd5), 1'b0);
      check("t4_drop_err", 64'(drop_err), 64'd1);
      idle(1, 1'b0);
      out_ready = 1'b1;
      check_tile("t3_first", out_tile, tile_fill(32'd10));
      step();
      check("t3_second_valid", 64'(out_valid), 64'd1);
      check_tile("t3_second", out_tile, tile_fill(32'd20));
      check("t3_in_ready_back", 64'(in_ready), 64'd1);
      idle(2, 1'b1);

      // Reset mid-accumulation
      send(tile_fill(32'd7), 1'b1);
      send(tile_fill(32'd7), 1'b1);
      rst = 1'b1;
      idle(1, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send(tile_fill(32'd1), 1'b1);
      check_tile("t5_sum", out_tile, tile_fill(32'd4));
      idle(1, 1'b1);
      check("t5_tc", 64'(tile_count), 64'd1);

      // Completion in the same cycle out_ready rises: no FULL entry
      for (int i = 0; i < 4; i++) send(tile_fill(32'd1), 1'b1);
      idle(1, 1'b0);
      for (int i = 0; i < 3; i++) send(tile_fill(32'd3), 1'b0);
      send(tile_fill(32'd3), 1'b1);
      check("t6_in_ready", 64'(in_ready), 64'd1);
      check_tile("t6_new", out_tile, tile_fill(32'd12));
      idle(2, 1'b1);

      // Randomized traffic with occasional reset
      for (int c = 0; c < 800; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ($urandom_range(0, 9) < 5);
         in_tile   = tile_rand();
         step();
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      idle(4, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
